// File: rtl/m68k_cs_pkg.sv
// m68k_cs_pkg: FSM encoding, default widths and per-PCB region tables for m68k_cs_waitgen
package m68k_cs_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_BERR} cs_state_e;

    localparam int DEF_NUM_REGIONS = 16;
    localparam int DEF_ADDR_W      = 24;
    localparam int DEF_WS_W        = 4;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] base;
        logic [DEF_ADDR_W-1:0] limit;
        logic [DEF_WS_W-1:0]   ws;
        logic                  rd_ok;
        logic                  wr_ok;
    } region_t;

    localparam int PCB_REGIONS = 4;

    localparam region_t SKYADV [PCB_REGIONS] = '{
        '{24'h000000, 24'h03ffff, 4'd0, 1'b1, 1'b0},
        '{24'h040000, 24'h043fff, 4'd0, 1'b1, 1'b1},
        '{24'h080000, 24'h08000f, 4'd2, 1'b1, 1'b1},
        '{24'h100000, 24'h100fff, 4'd1, 1'b1, 1'b1}
    };

    localparam region_t GOLDMEDL [PCB_REGIONS] = '{
        '{24'h000000, 24'h07ffff, 4'd0, 1'b1, 1'b0},
        '{24'h080000, 24'h083fff, 4'd0, 1'b1, 1'b1},
        '{24'h0c0000, 24'h0c001f, 4'd3, 1'b1, 1'b1},
        '{24'h200000, 24'h2007ff, 4'd1, 1'b1, 1'b1}
    };

    localparam region_t SKYSOLDR [PCB_REGIONS] = '{
        '{24'h000000, 24'h03ffff, 4'd0, 1'b1, 1'b0},
        '{24'h040000, 24'h047fff, 4'd0, 1'b1, 1'b1},
        '{24'h080000, 24'h08001f, 4'd2, 1'b1, 1'b1},
        '{24'h300000, 24'h300fff, 4'd1, 1'b1, 1'b1}
    };

endpackage

// File: rtl/cs_region_match.sv
// cs_region_match: combinational priority match of an address against the region table
module cs_region_match
    import m68k_cs_pkg::*;
#(
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WS_W        = DEF_WS_W,
    parameter int IDX_W       = $clog2(DEF_NUM_REGIONS)
) (
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_limit,
    input  logic [NUM_REGIONS*WS_W-1:0]   region_ws,
    input  logic [NUM_REGIONS-1:0]        region_en,
    input  logic [NUM_REGIONS-1:0]        region_rd_ok,
    input  logic [NUM_REGIONS-1:0]        region_wr_ok,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          rw,
    output logic                          hit,
    output logic [IDX_W-1:0]              win,
    output logic [WS_W-1:0]               win_ws
);

    // Scan from lowest priority upward so the lowest matching index is written last and wins
    always_comb begin
        hit    = 1'b0;
        win    = '0;
        win_ws = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (region_en[i] &&
                addr >= region_base[i*ADDR_W +: ADDR_W] &&
                addr <= region_limit[i*ADDR_W +: ADDR_W] &&
                (rw ? region_rd_ok[i] : region_wr_ok[i])) begin
                hit    = 1'b1;
                win    = IDX_W'(i);
                win_ws = region_ws[i*WS_W +: WS_W];
            end
        end
    end

endmodule

// File: rtl/m68k_cs_waitgen.sv
// m68k_cs_waitgen: table-driven 68000 chip-select decode with per-region DTACK wait states.
// Optional feature macro CS_BUS_ERROR_EN: unmapped accesses time out into BERR instead of a dummy DTACK.
module m68k_cs_waitgen
    import m68k_cs_pkg::*;
#(
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WS_W        = DEF_WS_W,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_limit,
    input  logic [NUM_REGIONS*WS_W-1:0]   region_ws,
    input  logic [NUM_REGIONS-1:0]        region_en,
    input  logic [NUM_REGIONS-1:0]        region_rd_ok,
    input  logic [NUM_REGIONS-1:0]        region_wr_ok,
    input  logic [ADDR_W-1:0]             m68k_a,
    input  logic                          m68k_as_n,
    input  logic                          m68k_rw,
    output logic [NUM_REGIONS-1:0]        cs,
    output logic [$clog2(NUM_REGIONS)-1:0] hit_idx,
    output logic                          unmapped,
    output logic                          m68k_dtack_n,
    output logic                          m68k_berr_n
);

    localparam int IDX_W = $clog2(NUM_REGIONS);
`ifdef CS_BUS_ERROR_EN
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (TO_W > WS_W) ? TO_W : WS_W;
`else
    localparam int CNT_W = WS_W;
`endif

    logic                   hit;
    logic [IDX_W-1:0]       win;
    logic [WS_W-1:0]        win_ws;
    cs_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REGIONS-1:0] cs_q, cs_d;
    logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
    logic                   unmapped_q, unmapped_d;
    logic                   dtack_n_q, dtack_n_d;
`ifdef CS_BUS_ERROR_EN
    logic                   berr_n_q, berr_n_d;
`endif

    cs_region_match #(
        .NUM_REGIONS(NUM_REGIONS),
        .ADDR_W     (ADDR_W),
        .WS_W       (WS_W),
        .IDX_W      (IDX_W)
    ) u_match (
        .region_base (region_base),
        .region_limit(region_limit),
        .region_ws   (region_ws),
        .region_en   (region_en),
        .region_rd_ok(region_rd_ok),
        .region_wr_ok(region_wr_ok),
        .addr        (m68k_a),
        .rw          (m68k_rw),
        .hit         (hit),
        .win         (win),
        .win_ws      (win_ws)
    );

    // Decode on AS, count wait states, then acknowledge until AS is released.
    // A zero-wait access skips WAIT so DTACK lands together with the chip select.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cs_d       = cs_q;
        hit_idx_d  = hit_idx_q;
        unmapped_d = unmapped_q;
        dtack_n_d  = dtack_n_q;
`ifdef CS_BUS_ERROR_EN
        berr_n_d   = berr_n_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!m68k_as_n) begin
                    if (hit) begin
                        cs_d       = NUM_REGIONS'(1) << win;
                        hit_idx_d  = win;
                        unmapped_d = 1'b0;
                        if (win_ws == '0) begin
                            dtack_n_d = 1'b0;
                            state_d   = ST_ACK;
                        end else begin
                            cnt_d   = CNT_W'(win_ws) - CNT_W'(1);
                            state_d = ST_WAIT;
                        end
                    end else begin
                        cs_d       = '0;
                        hit_idx_d  = '0;
                        unmapped_d = 1'b1;
`ifdef CS_BUS_ERROR_EN
                        cnt_d      = CNT_W'(TIMEOUT - 1);
                        state_d    = ST_WAIT;
`else
                        cnt_d      = '0;
                        dtack_n_d  = 1'b0;
                        state_d    = ST_ACK;
`endif
                    end
                end
            end
            ST_WAIT: begin
                if (m68k_as_n) begin
                    cs_d       = '0;
                    hit_idx_d  = '0;
                    unmapped_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else if (cnt_q == '0) begin
`ifdef CS_BUS_ERROR_EN
                    if (unmapped_q) begin
                        berr_n_d = 1'b0;
                        state_d  = ST_BERR;
                    end else begin
                        dtack_n_d = 1'b0;
                        state_d   = ST_ACK;
                    end
`else
                    dtack_n_d = 1'b0;
                    state_d   = ST_ACK;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (m68k_as_n) begin
                    cs_d       = '0;
                    hit_idx_d  = '0;
                    unmapped_d = 1'b0;
                    dtack_n_d  = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
`ifdef CS_BUS_ERROR_EN
            ST_BERR: begin
                if (m68k_as_n) begin
                    berr_n_d   = 1'b1;
                    unmapped_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset returns the bus to idle immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cs_q       <= '0;
            hit_idx_q  <= '0;
            unmapped_q <= 1'b0;
            dtack_n_q  <= 1'b1;
`ifdef CS_BUS_ERROR_EN
            berr_n_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cs_q       <= cs_d;
            hit_idx_q  <= hit_idx_d;
            unmapped_q <= unmapped_d;
            dtack_n_q  <= dtack_n_d;
`ifdef CS_BUS_ERROR_EN
            berr_n_q   <= berr_n_d;
`endif
        end
    end

    assign cs           = cs_q;
    assign hit_idx      = hit_idx_q;
    assign unmapped     = unmapped_q;
    assign m68k_dtack_n = dtack_n_q;
`ifdef CS_BUS_ERROR_EN
    assign m68k_berr_n  = berr_n_q;
`else
    assign m68k_berr_n  = 1'b1;
`endif

endmodule

// File: tb/tb_m68k_cs_waitgen.sv
// tb_m68k_cs_waitgen: directed bench with a cycle-count reference model for m68k_cs_waitgen
module tb_m68k_cs_waitgen;

    localparam int NR = 16;
    localparam int AW = 24;
    localparam int WW = 4;
`ifdef CS_BUS_ERROR_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NR*AW-1:0] region_base, region_limit;
    logic [NR*WW-1:0] region_ws;
    logic [NR-1:0] region_en, region_rd_ok, region_wr_ok;
    logic [AW-1:0] m68k_a = '0;
    logic m68k_as_n = 1'b1;
    logic m68k_rw = 1'b1;
    logic [NR-1:0] cs;
    logic [3:0] hit_idx;
    logic unmapped, m68k_dtack_n, m68k_berr_n;

    logic [AW-1:0] t_base [NR];
    logic [AW-1:0] t_limit [NR];
    logic [WW-1:0] t_ws [NR];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            region_base[i*AW +: AW]  = t_base[i];
            region_limit[i*AW +: AW] = t_limit[i];
            region_ws[i*WW +: WW]    = t_ws[i];
        end
    end

    m68k_cs_waitgen #(.NUM_REGIONS(NR), .ADDR_W(AW), .WS_W(WW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .region_base(region_base), .region_limit(region_limit), .region_ws(region_ws),
        .region_en(region_en), .region_rd_ok(region_rd_ok), .region_wr_ok(region_wr_ok),
        .m68k_a(m68k_a), .m68k_as_n(m68k_as_n), .m68k_rw(m68k_rw),
        .cs(cs), .hit_idx(hit_idx), .unmapped(unmapped),
        .m68k_dtack_n(m68k_dtack_n), .m68k_berr_n(m68k_berr_n)
    );

    // Reference: an access is a window of edges while AS stays low; outputs follow from its age.
    function automatic int find(logic [AW-1:0] a, logic rw);
        for (int i = 0; i < NR; i++)
            if (region_en[i] && t_base[i] <= a && a <= t_limit[i] && (rw ? region_rd_ok[i] : region_wr_ok[i]))
                return i;
        return -1;
    endfunction

    bit m_act = 1'b0;
    int m_win = -1;
    int m_age = 0;
    int m_ws = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_act <= 1'b0;
        else if (!m_act) begin
            if (!m68k_as_n) begin
                m_act <= 1'b1;
                m_age <= 0;
                m_win <= find(m68k_a, m68k_rw);
                m_ws  <= (find(m68k_a, m68k_rw) < 0) ? 0 : int'(t_ws[find(m68k_a, m68k_rw)]);
            end
        end else if (m68k_as_n) m_act <= 1'b0;
        else m_age <= m_age + 1;
    end

    logic [NR-1:0] e_cs;
    logic [3:0] e_hit;
    logic e_unm, e_dt, e_be;

    always_comb begin
        e_cs = '0; e_hit = '0; e_unm = 1'b0; e_dt = 1'b1; e_be = 1'b1;
        if (m_act) begin
            if (m_win >= 0) begin
                e_cs  = NR'(1) << m_win;
                e_hit = 4'(m_win);
                e_dt  = !(m_age >= m_ws);
            end else begin
                e_unm = 1'b1;
`ifdef CS_BUS_ERROR_EN
                e_be = !(m_age >= TO);
`else
                e_dt = 1'b0;
`endif
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cs", 32'(cs), 32'(e_cs));
        chk("hit_idx", 32'(hit_idx), 32'(e_hit));
        chk("unmapped", 32'(unmapped), 32'(e_unm));
        chk("dtack_n", 32'(m68k_dtack_n), 32'(e_dt));
        chk("berr_n", 32'(m68k_berr_n), 32'(e_be));
    end

    task automatic set_region(int i, logic [AW-1:0] b, logic [AW-1:0] l, logic [WW-1:0] w, logic rd, logic wr);
        t_base[i] = b; t_limit[i] = l; t_ws[i] = w;
        region_en[i] = 1'b1; region_rd_ok[i] = rd; region_wr_ok[i] = wr;
    endtask

    task automatic start(logic [AW-1:0] addr, logic rw);
        @(negedge clk);
        m68k_a = addr; m68k_rw = rw; m68k_as_n = 1'b0;
    endtask

    task automatic release_as(string name);
        m68k_as_n = 1'b1;
        @(negedge clk);
        chk({name, "_end_cs"}, 32'(cs), 32'h0);
        chk({name, "_end_dtack"}, 32'(m68k_dtack_n), 32'h1);
    endtask

    logic [AW-1:0] mix_a [6] = '{24'h000100, 24'h400000, 24'h100fff, 24'h1fffff, 24'h500000, 24'h900000};
    logic          mix_rw [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int            mix_hold [6] = '{1, 5, 3, 0, 2, 1};

    initial begin
        for (int i = 0; i < NR; i++) begin t_base[i] = '0; t_limit[i] = '0; t_ws[i] = '0; end
        region_en = '0; region_rd_ok = '0; region_wr_ok = '0;
        repeat (2) @(negedge clk);
        chk("rst_cs", 32'(cs), 32'h0);
        chk("rst_dtack", 32'(m68k_dtack_n), 32'h1);
        chk("rst_berr", 32'(m68k_berr_n), 32'h1);
        chk("rst_unmapped", 32'(unmapped), 32'h0);
        reset_n = 1'b1;
        set_region(0, 24'h000000, 24'h03ffff, 4'd0, 1'b1, 1'b1);
        set_region(1, 24'h100000, 24'h1fffff, 4'd0, 1'b1, 1'b1);
        set_region(2, 24'h100000, 24'h100fff, 4'd2, 1'b1, 1'b1);
        set_region(3, 24'h400000, 24'h401fff, 4'd3, 1'b1, 1'b1);
        set_region(5, 24'h500000, 24'h50ffff, 4'd0, 1'b1, 1'b0);
        set_region(6, 24'h600000, 24'h6fffff, 4'd7, 1'b1, 1'b1);
        set_region(7, 24'h700100, 24'h700000, 4'd0, 1'b1, 1'b1);

        start(24'h001234, 1'b1);
        @(negedge clk);
        chk("t1_cs", 32'(cs), 32'h1);
        chk("t1_dtack", 32'(m68k_dtack_n), 32'h0);
        @(negedge clk);
        chk("t1_dtack_hold", 32'(m68k_dtack_n), 32'h0);
        release_as("t1");

        start(24'h400010, 1'b0);
        @(negedge clk);
        chk("t2_cs", 32'(cs), 32'h8);
        chk("t2_hit", 32'(hit_idx), 32'h3);
        t_ws[3] = 4'd0;
        repeat (2) @(negedge clk);
        chk("t2_dtack_k3", 32'(m68k_dtack_n), 32'h1);
        @(negedge clk);
        chk("t2_dtack_k4", 32'(m68k_dtack_n), 32'h0);
        t_ws[3] = 4'd3;
        release_as("t2");

        start(24'h100800, 1'b1);
        @(negedge clk);
        chk("t3_cs", 32'(cs), 32'h2);
        chk("t3_hit", 32'(hit_idx), 32'h1);
        release_as("t3");

        start(24'h500100, 1'b0);
        @(negedge clk);
        chk("t4_unmapped", 32'(unmapped), 32'h1);
        chk("t4_cs", 32'(cs), 32'h0);
`ifdef CS_BUS_ERROR_EN
        repeat (7) @(negedge clk);
        chk("t4_berr_k8", 32'(m68k_berr_n), 32'h1);
        @(negedge clk);
        chk("t4_berr_k9", 32'(m68k_berr_n), 32'h0);
        chk("t4_dtack_k9", 32'(m68k_dtack_n), 32'h1);
`else
        chk("t4_dtack", 32'(m68k_dtack_n), 32'h0);
`endif
        release_as("t4");
        chk("t4_berr_end", 32'(m68k_berr_n), 32'h1);

        start(24'h500100, 1'b1);
        @(negedge clk);
        chk("t4r_cs", 32'(cs), 32'h20);
        release_as("t4r");

        start(24'h700080, 1'b1);
        @(negedge clk);
        chk("empty_unmapped", 32'(unmapped), 32'h1);
        release_as("empty");

        start(24'h600000, 1'b1);
        @(negedge clk);
        chk("t5_cs", 32'(cs), 32'h40);
        repeat (2) @(negedge clk);
        chk("t5_dtack_k3", 32'(m68k_dtack_n), 32'h1);
        m68k_as_n = 1'b1;
        @(negedge clk);
        chk("t5_abort_cs", 32'(cs), 32'h0);
        chk("t5_abort_dtack", 32'(m68k_dtack_n), 32'h1);
        m68k_a = 24'h001000; m68k_rw = 1'b1; m68k_as_n = 1'b0;
        @(negedge clk);
        chk("t5_next_cs", 32'(cs), 32'h1);
        chk("t5_next_dtack", 32'(m68k_dtack_n), 32'h0);
        release_as("t5");

        start(24'h000010, 1'b1);
        @(negedge clk);
        chk("t6_ack", 32'(m68k_dtack_n), 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_cs", 32'(cs), 32'h0);
        chk("t6_rst_dtack", 32'(m68k_dtack_n), 32'h1);
        chk("t6_rst_berr", 32'(m68k_berr_n), 32'h1);
        m68k_as_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        start(24'h002000, 1'b1);
        @(negedge clk);
        chk("t6_after_cs", 32'(cs), 32'h1);
        chk("t6_after_dtack", 32'(m68k_dtack_n), 32'h0);
        release_as("t6");

        for (int j = 0; j < 6; j++) begin
            start(mix_a[j], mix_rw[j]);
            repeat (mix_hold[j] + 1) @(negedge clk);
            m68k_as_n = 1'b1;
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
